sip_shift_accumulator: RTL and testbench

- Downstream of the SIP dot-product adder tree; consumes one signed dot sum per cycle.
- Each sum is a partial product of a bit-split (2b-slice) multiply-accumulate. The block shifts each sum by its slice significance and accumulates the beats of one group into a wide signed result.
- Emits one result per group through a valid/ready output register, with backpressure toward the adder stage.

---
 rtl/sip_shift_accumulator_if.sv | 31 +++
 rtl/sip_shift_accumulator.sv | 184 ++++++++++++++++++
 tb/tb_sip_shift_accumulator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sip_shift_accumulator_if.sv
// Stream interface between the SIP adder tree, the shift accumulator and the result consumer.
// Carries the partial-sum beat channel and the valid/ready result channel.
interface sip_shift_accumulator_if #(
  parameter int BITS_IN  = 10,
  parameter int BITS_ACC = 24,
  parameter int SHIFT_W  = 4,
  parameter int CNT_W    = 5
);
  logic signed [BITS_IN-1:0]  i_Psum;
  logic        [SHIFT_W-1:0]  i_Shift;
  logic                       i_Valid;
  logic                       i_Last;
  logic                       i_Flush;
  logic                       o_Ready;
  logic signed [BITS_ACC-1:0] o_Acc;
  logic        [CNT_W-1:0]    o_Beats;
  logic                       o_Forced;
  logic                       o_Ovf;
  logic                       o_Valid;
  logic                       i_Ready;

  modport slave (
    input  i_Psum, i_Shift, i_Valid, i_Last, i_Flush, i_Ready,
    output o_Ready, o_Acc, o_Beats, o_Forced, o_Ovf, o_Valid
  );

  modport master (
    output i_Psum, i_Shift, i_Valid, i_Last, i_Flush, i_Ready,
    input  o_Ready, o_Acc, o_Beats, o_Forced, o_Ovf, o_Valid
  );
endinterface

// File: rtl/sip_shift_accumulator.sv
// Shifts each signed dot-sum by its slice significance and accumulates one group into a wide result.
// Optional macro SIP_ACC_SATURATE_EN: saturating arithmetic with a sticky per-group overflow flag.
module sip_shift_accumulator #(
  parameter int BITS_IN   = 10,
  parameter int BITS_ACC  = 24,
  parameter int SHIFT_W   = 4,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic                     i_CLK,
  input  logic                     i_RSTn,
  sip_shift_accumulator_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  localparam logic signed [BITS_ACC-1:0] ACC_ZERO = {BITS_ACC{1'b0}};
  localparam logic signed [BITS_ACC-1:0] ACC_MAX  = {1'b0, {(BITS_ACC-1){1'b1}}};
  localparam logic signed [BITS_ACC-1:0] ACC_MIN  = {1'b1, {(BITS_ACC-1){1'b0}}};
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0]           CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]                ACC_W32  = 32'(BITS_ACC);

  state_e                     state_q, state_d;
  logic signed [BITS_ACC-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       rdy_en_q;

  logic                       out_valid_q;
  logic signed [BITS_ACC-1:0] out_acc_q;
  logic        [CNT_W-1:0]    out_beats_q;
  logic                       out_forced_q;
  logic                       out_ovf_q;

  logic                       ready_s;
  logic                       accept_s;
  logic                       close_s;
  logic                       load_s;
  logic                       shift_big_s;
  logic                       beat_ovf_s;
  logic signed [BITS_ACC-1:0] sext_s;
  logic signed [BITS_ACC-1:0] term_s;
  logic signed [BITS_ACC-1:0] base_s;
  logic signed [BITS_ACC-1:0] sum_raw_s;
  logic signed [BITS_ACC-1:0] sum_s;

  // ready is held low until the first clock after reset so nothing is taken while in reset
  assign ready_s     = rdy_en_q & (~out_valid_q | bus.i_Ready);
  assign accept_s    = bus.i_Valid & ready_s & ~bus.i_Flush;
  assign close_s     = bus.i_Last | (cnt_q == CNT_LAST);
  assign shift_big_s = ({{(32-SHIFT_W){1'b0}}, bus.i_Shift} >= ACC_W32);

  // Beat datapath: sign-extend, shift by slice significance, add to the running group sum
  always_comb begin
    sext_s     = {{(BITS_ACC-BITS_IN){bus.i_Psum[BITS_IN-1]}}, bus.i_Psum};
    term_s     = ACC_ZERO;
    beat_ovf_s = 1'b0;
    if (shift_big_s) begin
      term_s = ACC_ZERO;
`ifdef SIP_ACC_SATURATE_EN
      if (sext_s != ACC_ZERO) begin
        beat_ovf_s = 1'b1;
        term_s     = sext_s[BITS_ACC-1] ? ACC_MIN : ACC_MAX;
      end else begin
        term_s = ACC_ZERO;
      end
`endif
    end else begin
      term_s = sext_s << bus.i_Shift;
`ifdef SIP_ACC_SATURATE_EN
      // significant bits were lost if shifting back does not recover the operand
      if ((term_s >>> bus.i_Shift) != sext_s) begin
        beat_ovf_s = 1'b1;
        term_s     = sext_s[BITS_ACC-1] ? ACC_MIN : ACC_MAX;
      end else begin
        beat_ovf_s = 1'b0;
      end
`endif
    end
    base_s    = (state_q == ST_ACC) ? acc_q : ACC_ZERO;
    sum_raw_s = base_s + term_s;
    sum_s     = sum_raw_s;
`ifdef SIP_ACC_SATURATE_EN
    if ((base_s[BITS_ACC-1] == term_s[BITS_ACC-1]) &&
        (sum_raw_s[BITS_ACC-1] != base_s[BITS_ACC-1])) begin
      sum_s      = base_s[BITS_ACC-1] ? ACC_MIN : ACC_MAX;
      beat_ovf_s = 1'b1;
    end else begin
      sum_s = sum_raw_s;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (bus.i_Flush) begin
      state_d = ST_IDLE;
    end else if (accept_s) begin
      state_d = close_s ? ST_IDLE : ST_ACC;
    end else begin
      state_d = state_q;
    end
  end

  // Accumulator/counter updates and result-load strobe
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    load_s = 1'b0;
    if (bus.i_Flush) begin
      acc_d = ACC_ZERO;
      cnt_d = CNT_ZERO;
      ovf_d = 1'b0;
    end else if (accept_s) begin
      if (close_s) begin
        acc_d  = ACC_ZERO;
        cnt_d  = CNT_ZERO;
        ovf_d  = 1'b0;
        load_s = 1'b1;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CNT_ONE;
        ovf_d = ovf_q | beat_ovf_s;
      end
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
    end
  end

  // State and group accumulator registers
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q  <= ST_IDLE;
      acc_q    <= ACC_ZERO;
      cnt_q    <= CNT_ZERO;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Result output register; data held while the consumer stalls
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      out_valid_q  <= 1'b0;
      out_acc_q    <= ACC_ZERO;
      out_beats_q  <= CNT_ZERO;
      out_forced_q <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else if (load_s) begin
      out_valid_q  <= 1'b1;
      out_acc_q    <= sum_s;
      out_beats_q  <= cnt_q + CNT_ONE;
      out_forced_q <= ~bus.i_Last;
      out_ovf_q    <= ovf_q | beat_ovf_s;
    end else if (bus.i_Ready) begin
      out_valid_q  <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_q;
    end
  end

  assign bus.o_Ready  = ready_s;
  assign bus.o_Valid  = out_valid_q;
  assign bus.o_Acc    = out_acc_q;
  assign bus.o_Beats  = out_beats_q;
  assign bus.o_Forced = out_forced_q;
  assign bus.o_Ovf    = out_ovf_q;

endmodule

// File: tb/tb_sip_shift_accumulator.sv
// Directed bench for sip_shift_accumulator with a queue scoreboard fed by a behavioural model.
module tb_sip_shift_accumulator;

  localparam int BITS_IN   = 10;
  localparam int BITS_ACC  = 24;
  localparam int SHIFT_W   = 4;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = 5;
  localparam int AMAX      = (2 ** (BITS_ACC - 1)) - 1;
  localparam int AMIN      = -(2 ** (BITS_ACC - 1));

  typedef struct packed {
    logic [BITS_ACC-1:0] acc;
    logic [CNT_W-1:0]    beats;
    logic                forced;
    logic                ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sip_shift_accumulator_if #(
    .BITS_IN(BITS_IN), .BITS_ACC(BITS_ACC), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
  ) bus ();

  sip_shift_accumulator #(
    .BITS_IN(BITS_IN), .BITS_ACC(BITS_ACC), .SHIFT_W(SHIFT_W),
    .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  exp_t                       sb[$];
  int                         n_checks = 0;
  int                         n_err    = 0;
  logic signed [BITS_ACC-1:0] m_acc;
  int                         m_cnt;
  logic                       m_ovf;
  logic                       prev_v;
  logic [BITS_ACC-1:0]        hold_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_beat(input logic signed [BITS_IN-1:0] p, input logic [SHIFT_W-1:0] sh,
                            input logic last);
    logic signed [BITS_ACC-1:0] sext, term, base, sum;
    logic signed [BITS_ACC+1:0] wide;
    logic                       ov;
    exp_t                       e;
    sext = p;
    ov   = 1'b0;
    if (int'(sh) >= BITS_ACC) term = '0;
    else                      term = sext << sh;
`ifdef SIP_ACC_SATURATE_EN
    if (int'(sh) >= BITS_ACC) begin
      if (sext != 0) begin ov = 1'b1; term = (p < 0) ? AMIN[BITS_ACC-1:0] : AMAX[BITS_ACC-1:0]; end
    end else if ((term >>> sh) != sext) begin
      ov = 1'b1; term = (p < 0) ? AMIN[BITS_ACC-1:0] : AMAX[BITS_ACC-1:0];
    end
`endif
    base = (m_cnt == 0) ? '0 : m_acc;
    wide = base + term;
    sum  = wide[BITS_ACC-1:0];
`ifdef SIP_ACC_SATURATE_EN
    if (wide > AMAX)      begin sum = AMAX[BITS_ACC-1:0]; ov = 1'b1; end
    else if (wide < AMIN) begin sum = AMIN[BITS_ACC-1:0]; ov = 1'b1; end
`endif
    m_ovf = m_ovf | ov;
    if (last || (m_cnt == MAX_BEATS - 1)) begin
      e.acc    = sum;
      e.beats  = CNT_W'(m_cnt + 1);
      e.forced = ~last;
`ifdef SIP_ACC_SATURATE_EN
      e.ovf    = m_ovf;
`else
      e.ovf    = 1'b0;
`endif
      sb.push_back(e);
      model_clear();
    end else begin
      m_acc = sum;
      m_cnt++;
    end
  endtask

  // Called #1 after each rising edge; rdy_edge is the i_Ready value seen at that edge
  task automatic sample(input logic rdy_edge);
    exp_t e;
    if (bus.o_Valid && (!prev_v || rdy_edge)) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("acc",    32'($unsigned(bus.o_Acc)), 32'(e.acc));
        chk("beats",  32'(bus.o_Beats),  32'(e.beats));
        chk("forced", 32'(bus.o_Forced), 32'(e.forced));
        chk("ovf",    32'(bus.o_Ovf),    32'(e.ovf));
        hold_acc = e.acc;
      end
    end else if (bus.o_Valid && prev_v) begin
      chk("acc_stable", 32'($unsigned(bus.o_Acc)), 32'(hold_acc));
    end
    prev_v = bus.o_Valid;
  endtask

  task automatic beat(input int p, input int sh, input logic last, input logic flush);
    logic acc_now, rdy;
    bit   done;
    done        = 1'b0;
    bus.i_Psum  = BITS_IN'(p);
    bus.i_Shift = SHIFT_W'(sh);
    bus.i_Last  = last;
    bus.i_Flush = flush;
    bus.i_Valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      acc_now = bus.o_Ready;
      rdy     = bus.i_Ready;
      if (flush) begin
        model_clear();
        done = 1'b1;
      end else if (acc_now) begin
        model_beat(BITS_IN'(p), SHIFT_W'(sh), last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      sample(rdy);
    end
    chk("beat_accept", 32'(done), 32'd1);
    bus.i_Valid = 1'b0;
    bus.i_Last  = 1'b0;
    bus.i_Flush = 1'b0;
  endtask

  task automatic idle(input int n);
    logic rdy;
    bus.i_Valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      rdy = bus.i_Ready;
      @(posedge clk);
      #1;
      sample(rdy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    bus.i_Psum  = '0;
    bus.i_Shift = '0;
    bus.i_Valid = 1'b0;
    bus.i_Last  = 1'b0;
    bus.i_Flush = 1'b0;
    bus.i_Ready = 1'b1;
    prev_v      = 1'b0;
    hold_acc    = '0;
    model_clear();

    #2;
    chk("rst_valid", 32'(bus.o_Valid), 32'd0);
    chk("rst_acc",   32'($unsigned(bus.o_Acc)), 32'd0);
    chk("rst_beats", 32'(bus.o_Beats), 32'd0);
    chk("rst_ready", 32'(bus.o_Ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_up", 32'(bus.o_Ready), 32'd1);

    // bit-split combine: 3 - 8 + 16
    beat(3, 0, 1'b0, 1'b0);
    beat(-2, 2, 1'b0, 1'b0);
    beat(1, 4, 1'b1, 1'b0);
    chk("latency", 32'(bus.o_Valid), 32'd1);

    // forced close after MAX_BEATS, then a 17th beat opening a new group
    for (int i = 0; i < MAX_BEATS; i++) beat(1, 0, 1'b0, 1'b0);
    beat(2, 0, 1'b1, 1'b0);
    idle(2);

    // backpressure: pending result, second group stalls until i_Ready rises
    bus.i_Ready = 1'b0;
    beat(9, 0, 1'b1, 1'b0);
    bus.i_Psum  = BITS_IN'(7);
    bus.i_Shift = '0;
    bus.i_Last  = 1'b1;
    bus.i_Valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ready_stall", 32'(bus.o_Ready), 32'd0);
      @(posedge clk);
      #1;
      sample(1'b0);
    end
    bus.i_Ready = 1'b1;
    beat(7, 0, 1'b1, 1'b0);
    idle(2);

    // flush drops the partial group and the beat presented with it
    beat(4, 0, 1'b0, 1'b0);
    beat(4, 0, 1'b0, 1'b0);
    beat(100, 0, 1'b1, 1'b1);
    beat(2, 0, 1'b1, 1'b0);
    idle(2);

    // overflow: wraps by default, saturates with the macro
    beat(511, 14, 1'b0, 1'b0);
    beat(511, 14, 1'b1, 1'b0);
    idle(2);

    // reset in the middle of a group
    beat(1, 0, 1'b0, 1'b0);
    beat(1, 0, 1'b0, 1'b0);
    beat(1, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.o_Valid), 32'd0);
    chk("midrst_acc",   32'($unsigned(bus.o_Acc)), 32'd0);
    model_clear();
    prev_v = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(bus.o_Ready), 32'd0);
    @(posedge clk);
    #1;
    beat(5, 0, 1'b1, 1'b0);
    idle(3);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
